// File: rtl/mul_accumulator.sv
// Multiply-accumulate stage: sums N_TERMS successive 8-bit products into an
// ACC_W-bit accumulator and hands the total off over a valid/ready port.
module mul_accumulator #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       prod,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] sum;

  // One extra bit catches the carry out of the accumulator for ovf.
  assign sum      = {1'b0, acc} + SUM_W'(prod);
  assign in_ready = (state == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      acc_out   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              acc_out   <= sum[ACC_W-1:0];
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          // A start coinciding with the handoff skips IDLE entirely.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state <= ACCUM;
              acc   <= '0;
              cnt   <= '0;
              ovf   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_accumulator.sv
// Scoreboard bench for mul_accumulator: a 12-bit and a 9-bit accumulator share
// stimulus; per-instance monitors pop expected results on each output handshake.
module tb_mul_accumulator;

  typedef struct packed {
    logic [11:0] acc;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  prod;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready12, ovf12, out_valid12;
  logic [11:0] acc12;
  logic        in_ready9, ovf9, out_valid9;
  logic [8:0]  acc9;

  exp_t q12[$];
  exp_t q9[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_accumulator #(.N_TERMS(4), .ACC_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready12), .acc_out(acc12), .ovf(ovf12),
    .out_valid(out_valid12), .out_ready(out_ready)
  );

  mul_accumulator #(.N_TERMS(4), .ACC_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .start(start), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready9), .acc_out(acc9), .ovf(ovf9),
    .out_valid(out_valid9), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [11:0] a12, input logic o12,
                      input logic [11:0] a9, input logic o9);
    q12.push_back('{acc: a12, ovf: o12});
    q9.push_back('{acc: a9, ovf: o9});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] p);
    prod     = p;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_acc12"},   32'(acc12), 0);
    check({tag, "_ovf12"},   32'(ovf12), 0);
    check({tag, "_valid12"}, 32'(out_valid12), 0);
    check({tag, "_ready12"}, 32'(in_ready12), 0);
    check({tag, "_acc9"},    32'(acc9), 0);
    check({tag, "_valid9"},  32'(out_valid9), 0);
  endtask

  // Monitors: compare on every completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid12 && out_ready) begin
      if (q12.size() == 0) begin
        check("spurious_out12", 32'(q12.size()), 1);
      end else begin
        exp_t e;
        e = q12.pop_front();
        check("sb_acc12", 32'(acc12), 32'(e.acc));
        check("sb_ovf12", 32'(ovf12), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid9 && out_ready) begin
      if (q9.size() == 0) begin
        check("spurious_out9", 32'(q9.size()), 1);
      end else begin
        exp_t e;
        e = q9.pop_front();
        check("sb_acc9", 32'(acc9), 32'(e.acc));
        check("sb_ovf9", 32'(ovf9), 32'(e.ovf));
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; prod = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    check_idle_outputs("reset");

    // Basic run: 4 x 225 = 900; the 9-bit instance wraps to 388 with ovf.
    out_ready = 1'b1;
    pulse_start();
    check("accum_in_ready", 32'(in_ready12), 1);
    push(12'd900, 1'b0, 12'd388, 1'b1);
    beat(8'd225);
    beat(8'd225);
    beat(8'd225);
    check("pre_last_valid", 32'(out_valid12), 0);
    beat(8'd225);
    check("latency_valid12", 32'(out_valid12), 1);
    check("latency_valid9",  32'(out_valid9), 1);
    check("hold_in_ready",   32'(in_ready12), 0);
    cycle();
    check("idle_valid", 32'(out_valid12), 0);
    check("idle_in_ready", 32'(in_ready12), 0);
    check("ovf_sticky9", 32'(ovf9), 1);

    // Bubbles, ignored start mid-run, then backpressure with junk inputs.
    out_ready = 1'b0;
    pulse_start();
    check("ovf_cleared9", 32'(ovf9), 0);
    push(12'd10, 1'b0, 12'd10, 1'b0);
    beat(8'd1);
    cycle();
    beat(8'd2);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    beat(8'd3);
    beat(8'd4);
    for (int i = 0; i < 5; i++) begin
      prod = 8'd99; in_valid = 1'b1; start = 1'b1;
      check("bp_acc",      32'(acc12), 10);
      check("bp_valid",    32'(out_valid12), 1);
      check("bp_in_ready", 32'(in_ready12), 0);
      cycle();
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    cycle();
    check("after_handoff_valid", 32'(out_valid12), 0);
    check("after_handoff_keep",  32'(acc12), 10);

    // Handoff restart: start together with out_ready goes straight to ACCUM.
    out_ready = 1'b0;
    pulse_start();
    push(12'd28, 1'b0, 12'd28, 1'b0);
    repeat (4) beat(8'd7);
    check("restart_hold_valid", 32'(out_valid12), 1);
    out_ready = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    check("restart_in_ready", 32'(in_ready12), 1);
    check("restart_valid",    32'(out_valid12), 0);
    push(12'd20, 1'b0, 12'd20, 1'b0);
    repeat (4) beat(8'd5);
    check("restart_done_valid", 32'(out_valid12), 1);
    cycle();

    // Reset mid-run: partial sum must not survive.
    pulse_start();
    beat(8'd9);
    beat(8'd9);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    cycle();
    cycle();
    rst_n = 1'b1;
    pulse_start();
    push(12'd4, 1'b0, 12'd4, 1'b0);
    repeat (4) beat(8'd1);
    cycle();
    cycle();

    check("q12_drained", 32'(q12.size()), 0);
    check("q9_drained",  32'(q9.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
